mdu_div_sequencer: RTL and testbench

//  Sequences the two divider IP cores (signed / unsigned, AXI-stream, non-abortable) on behalf of the EXE stage.

---
 rtl/mdu_div_sequencer.sv | 172 +++++++++++++++++
 tb/tb_mdu_div_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_div_sequencer.sv
// Divide sequencer for the EXE stage: hands operands to the signed/unsigned AXI-stream divider
// cores, stalls the pipeline, writes HI/LO once per divide, drains flushed results, and has a watchdog.
module mdu_div_sequencer #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        aclk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_signed,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        flush,
    output logic        stall,
    output logic        s_tvalid,
    input  logic        s_tready,
    output logic        u_tvalid,
    input  logic        u_tready,
    output logic [31:0] dividend,
    output logic [31:0] divisor,
    input  logic        s_dout_valid,
    input  logic [63:0] s_dout,
    input  logic        u_dout_valid,
    input  logic [63:0] u_dout,
    output logic        hilo_we,
    output logic [31:0] lo_wdata,
    output logic [31:0] hi_wdata,
    output logic        wdog_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sel_signed;
    logic [31:0]      r_dividend;
    logic [31:0]      r_divisor;
    logic [63:0]      r_result;
    logic [CNT_W-1:0] r_cnt;

    logic             w_load_op;
    logic             w_load_res;
    logic             w_cnt_clr;
    logic             w_tready;
    logic             w_dout_valid;
    logic [63:0]      w_dout;
    logic             w_timeout;
    logic             w_counting;

    // Only the core that received the operands is ever listened to.
    assign w_tready     = r_sel_signed ? s_tready     : u_tready;
    assign w_dout_valid = r_sel_signed ? s_dout_valid : u_dout_valid;
    assign w_dout       = r_sel_signed ? s_dout       : u_dout;
    assign w_timeout    = (r_cnt == CNT_W'(TIMEOUT));
    assign w_counting   = (r_state == S_WAIT) || (r_state == S_DRAIN);

    // NOTE: sequential state uses nonblocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_sel_signed <= 1'b0;
            r_dividend   <= '0;
            r_divisor    <= '0;
        end else if (w_load_op) begin
            r_sel_signed <= req_signed;
            r_dividend   <= req_a;
            r_divisor    <= req_b;
        end
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_result <= '0;
        end else if (w_load_res) begin
            r_result <= w_dout;
        end
    end

    always_ff @(posedge aclk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_counting && !w_timeout) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // NOTE: every output and control of this block gets a default first, so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load_op   = 1'b0;
        w_load_res  = 1'b0;
        w_cnt_clr   = 1'b0;
        stall       = 1'b0;
        s_tvalid    = 1'b0;
        u_tvalid    = 1'b0;
        hilo_we     = 1'b0;
        wdog_err    = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Gated by rst so the stall output is also forced low while reset is held.
                stall = rst && req_valid && !flush;
                if (req_valid && !flush) begin
                    w_load_op   = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stall    = 1'b1;
                s_tvalid = r_sel_signed;
                u_tvalid = !r_sel_signed;
                if (w_tready) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = flush ? S_DRAIN : S_WAIT;
                end else if (flush) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (w_dout_valid) begin
                    w_load_res  = !flush;
                    w_state_nxt = flush ? S_IDLE : S_DONE;
                end else if (w_timeout) begin
                    wdog_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (flush) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                hilo_we     = !flush;
                w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                // A younger divide waits here until the flushed result has left the core.
                stall = req_valid;
                if (w_dout_valid) begin
                    w_state_nxt = S_IDLE;
                end else if (w_timeout) begin
                    wdog_err    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dividend = r_dividend;
    assign divisor  = r_divisor;
    assign lo_wdata = r_result[63:32];
    assign hi_wdata = r_result[31:0];

endmodule

// File: tb/tb_mdu_div_sequencer.sv
// Bench for mdu_div_sequencer: divider-core stubs, a pipeline driver, and a scoreboard that
// compares every HI/LO write against plain-arithmetic division of the issued operands.
module tb_mdu_div_sequencer;

    localparam int TIMEOUT = 64;

    logic        aclk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_signed = 1'b0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic        s_tvalid;
    logic        s_tready;
    logic        u_tvalid;
    logic        u_tready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        s_dout_valid = 1'b0;
    logic [63:0] s_dout = '0;
    logic        u_dout_valid = 1'b0;
    logic [63:0] u_dout = '0;
    logic        hilo_we;
    logic [31:0] lo_wdata;
    logic [31:0] hi_wdata;
    logic        wdog_err;

    always #5 aclk = ~aclk;

    mdu_div_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .aclk(aclk), .rst(rst), .req_valid(req_valid), .req_signed(req_signed),
        .req_a(req_a), .req_b(req_b), .flush(flush), .stall(stall),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .u_tvalid(u_tvalid), .u_tready(u_tready),
        .dividend(dividend), .divisor(divisor),
        .s_dout_valid(s_dout_valid), .s_dout(s_dout), .u_dout_valid(u_dout_valid), .u_dout(u_dout),
        .hilo_we(hilo_we), .lo_wdata(lo_wdata), .hi_wdata(hi_wdata), .wdog_err(wdog_err)
    );

    typedef struct { int due; logic [63:0] data; } pend_t;
    typedef struct { logic [31:0] lo; logic [31:0] hi; } exp_t;

    pend_t s_pend[$];
    pend_t u_pend[$];
    exp_t  exp_q[$];

    int n_checks = 0;
    int n_pass = 0;
    int n_we = 0;
    int cyc = 0;
    int lat_s = 34;
    int lat_u = 34;
    int s_hold = 0;
    int u_hold = 0;
    int s_tv_cnt = 0;
    int u_tv_cnt = 0;
    bit mute = 1'b0;
    bit noise = 1'b0;
    bit last_sel = 1'b0;

    assign s_tready = (s_tv_cnt >= s_hold);
    assign u_tready = (u_tv_cnt >= u_hold);

    // Reference divider: truncating division; x/0 gives quotient all-ones, remainder x.
    function automatic logic [63:0] ref_div(input bit sg, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '1;
            r = a;
        end else if (sg) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a;
                r = '0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Core stubs: fixed latency from handshake to dout_valid; optional noise on the idle core.
    logic        cap_s_tv, cap_s_tr, cap_u_tv, cap_u_tr;
    logic [31:0] cap_a, cap_b;
    pend_t       pe;

    always @(posedge aclk) begin
        cyc++;
        cap_s_tv = s_tvalid;
        cap_s_tr = s_tready;
        cap_u_tv = u_tvalid;
        cap_u_tr = u_tready;
        cap_a    = dividend;
        cap_b    = divisor;
        #1;
        if (cap_s_tv && !cap_s_tr) s_tv_cnt++;
        else s_tv_cnt = 0;
        if (cap_u_tv && !cap_u_tr) u_tv_cnt++;
        else u_tv_cnt = 0;
        if (cap_s_tv && cap_s_tr && !mute) begin
            pe.due  = cyc + lat_s - 1;
            pe.data = ref_div(1'b1, cap_a, cap_b);
            s_pend.push_back(pe);
        end
        if (cap_u_tv && cap_u_tr && !mute) begin
            pe.due  = cyc + lat_u - 1;
            pe.data = ref_div(1'b0, cap_a, cap_b);
            u_pend.push_back(pe);
        end
        if (s_pend.size() > 0 && s_pend[0].due <= cyc) begin
            s_dout_valid = 1'b1;
            s_dout       = s_pend[0].data;
            void'(s_pend.pop_front());
        end else begin
            s_dout_valid = noise && (last_sel == 1'b0) && (s_pend.size() == 0) && ($urandom_range(0, 3) == 0);
            s_dout       = {$urandom, $urandom};
        end
        if (u_pend.size() > 0 && u_pend[0].due <= cyc) begin
            u_dout_valid = 1'b1;
            u_dout       = u_pend[0].data;
            void'(u_pend.pop_front());
        end else begin
            u_dout_valid = noise && (last_sel == 1'b1) && (u_pend.size() == 0) && ($urandom_range(0, 3) == 0);
            u_dout       = {$urandom, $urandom};
        end
    end

    // Scoreboard monitor: every HI/LO write must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge aclk) begin
        if (rst && hilo_we) begin
            n_we++;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(hilo_we), 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("hilo_data", {lo_wdata, hi_wdata}, {mon_e.lo, mon_e.hi});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    // Pipeline driver: holds the request while stall=1; flush_at<0 means the divide must write.
    task automatic issue(input bit sg, input logic [31:0] a, input logic [31:0] b,
                         input int flush_at, input int hold,
                         output int n_stall, output int n_tv, output int n_tv_other,
                         output int we_k, output int op_bad);
        logic [63:0] r;
        exp_t        e;
        bit          done;
        n_stall = 0;
        n_tv = 0;
        n_tv_other = 0;
        we_k = -1;
        op_bad = 0;
        if (sg) s_hold = hold;
        else u_hold = hold;
        last_sel = sg;
        if (flush_at < 0) begin
            r = ref_div(sg, a, b);
            e.lo = r[63:32];
            e.hi = r[31:0];
            exp_q.push_back(e);
        end
        req_valid  = 1'b1;
        req_signed = sg;
        req_a      = a;
        req_b      = b;
        for (int k = 0; k <= 300; k++) begin
            flush = (k == flush_at);
            @(negedge aclk);
            if (stall) n_stall++;
            if (sg ? s_tvalid : u_tvalid) begin
                n_tv++;
                if (dividend !== a || divisor !== b) op_bad++;
            end
            if (sg ? u_tvalid : s_tvalid) n_tv_other++;
            if (hilo_we && we_k < 0) we_k = k;
            done = (k == flush_at) || !stall;
            if (!done && k == 300) check("issue_timeout", 64'(stall), 64'd0);
            @(posedge aclk);
            #1;
            flush = 1'b0;
            if (done) break;
        end
        req_valid = 1'b0;
    endtask

    int ns, ntv, nto, wk, ob, we_before, nw, st_after, lat, fa, hold;
    bit sg;
    logic [31:0] ra, rb;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge aclk);
        check("reset_ctrl", 64'({stall, s_tvalid, u_tvalid, hilo_we, wdog_err}), 64'd0);
        check("reset_operands", {dividend, divisor}, 64'd0);
        check("reset_result", {lo_wdata, hi_wdata}, 64'd0);
        rst = 1'b1;
        idle(2);

        // DIV -7/2, latency 34: write at cycle 36, stall high for cycles 0..35
        lat_s = 34;
        lat_u = 34;
        issue(1'b1, 32'hFFFF_FFF9, 32'd2, -1, 0, ns, ntv, nto, wk, ob);
        check("t1_we_cycle", 64'(wk), 64'(36));
        check("t1_stall_cycles", 64'(ns), 64'(36));
        check("t1_tvalid_cycles", 64'(ntv), 64'(1));
        check("t1_other_tvalid", 64'(nto), 64'(0));
        check("t1_result", {lo_wdata, hi_wdata}, {32'hFFFF_FFFD, 32'hFFFF_FFFF});
        idle(2);

        // DIVU 100/7 with three cycles of tready backpressure
        lat_u = 12;
        issue(1'b0, 32'd100, 32'd7, -1, 3, ns, ntv, nto, wk, ob);
        check("t2_tvalid_cycles", 64'(ntv), 64'(4));
        check("t2_operands_stable", 64'(ob), 64'(0));
        check("t2_we_cycle", 64'(wk), 64'(2 + 12 + 3));
        idle(2);

        // Flush 5 cycles into WAIT, then a second divide that must wait out the drain
        lat = 10;
        lat_u = lat;
        fa = 7;
        we_before = n_we;
        issue(1'b0, 32'd100, 32'd7, fa, 0, ns, ntv, nto, wk, ob);
        issue(1'b0, 32'd9, 32'd3, -1, 0, ns, ntv, nto, wk, ob);
        check("t3_we_cycle", 64'(wk), 64'((2 + lat - (fa + 1)) + 2 + lat));
        check("t3_stall_cycles", 64'(ns), 64'((2 + lat - (fa + 1)) + 2 + lat));
        check("t3_single_write", 64'(n_we - we_before), 64'(1));
        idle(2);

        // Flush coinciding with dout_valid, then flush in DONE: neither writes
        lat_s = lat;
        we_before = n_we;
        issue(1'b1, 32'hFFFF_FF00, 32'd5, 1 + lat, 0, ns, ntv, nto, wk, ob);
        issue(1'b0, 32'd77, 32'd4, 2 + lat, 0, ns, ntv, nto, wk, ob);
        idle(3);
        check("t4_flush_no_write", 64'(n_we - we_before), 64'd0);
        issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, 0, ns, ntv, nto, wk, ob);
        check("t4_next_we_cycle", 64'(wk), 64'(2 + lat));
        issue(1'b0, 32'd1234, 32'd0, -1, 0, ns, ntv, nto, wk, ob);
        check("t4_div0_we_cycle", 64'(wk), 64'(2 + lat));
        idle(2);

        // Lost dout_valid: watchdog pulse 64 cycles after WAIT entry, stall low right after
        mute = 1'b1;
        last_sel = 1'b1;
        s_hold = 0;
        req_valid = 1'b1;
        req_signed = 1'b1;
        req_a = 32'd50;
        req_b = 32'd5;
        wk = -1;
        nw = 0;
        st_after = 1;
        we_before = n_we;
        for (int k = 0; k < 90; k++) begin
            @(negedge aclk);
            if (wdog_err) begin
                nw++;
                if (wk < 0) wk = k;
            end
            if (wk >= 0 && k == wk + 1) st_after = int'(stall);
            @(posedge aclk);
            #1;
            if (wk >= 0 && k == wk) req_valid = 1'b0;
        end
        req_valid = 1'b0;
        mute = 1'b0;
        check("t5_wdog_cycle", 64'(wk), 64'(2 + TIMEOUT));
        check("t5_wdog_width", 64'(nw), 64'(1));
        check("t5_stall_after", 64'(st_after), 64'd0);
        check("t5_no_write", 64'(n_we - we_before), 64'd0);
        idle(2);

        // Reset during WAIT; the stale core result arriving later must not write
        lat_u = 20;
        u_hold = 0;
        last_sel = 1'b0;
        req_valid = 1'b1;
        req_signed = 1'b0;
        req_a = 32'd1000;
        req_b = 32'd3;
        idle(8);
        @(negedge aclk);
        #2;
        rst = 1'b0;
        #1;
        check("t6_rst_ctrl", 64'({stall, s_tvalid, u_tvalid, hilo_we, wdog_err}), 64'd0);
        check("t6_rst_operands", {dividend, divisor}, 64'd0);
        check("t6_rst_result", {lo_wdata, hi_wdata}, 64'd0);
        req_valid = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        rst = 1'b1;
        @(posedge aclk);
        #1;
        we_before = n_we;
        idle(30);
        check("t6_stale_no_write", 64'(n_we - we_before), 64'd0);
        issue(1'b0, 32'd1000, 32'd3, -1, 0, ns, ntv, nto, wk, ob);
        check("t6_after_reset_we_cycle", 64'(wk), 64'(2 + 20));
        idle(2);

        // Randomized divides with backpressure, flushes, varying latency and idle-core noise
        noise = 1'b1;
        for (int i = 0; i < 60; i++) begin
            sg = 1'($urandom_range(0, 1));
            ra = $urandom;
            if ($urandom_range(0, 15) == 0) rb = 32'd0;
            else if ($urandom_range(0, 1) == 1) rb = $urandom;
            else rb = 32'($urandom_range(1, 300));
            lat_s = int'($urandom_range(1, 20));
            lat_u = int'($urandom_range(1, 20));
            hold = int'($urandom_range(0, 3));
            lat = sg ? lat_s : lat_u;
            fa = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2 + lat + hold)) : -1;
            issue(sg, ra, rb, fa, hold, ns, ntv, nto, wk, ob);
            if (fa < 0) check("rand_write_seen", 64'(wk >= 0), 64'd1);
            check("rand_other_core_idle", 64'(nto), 64'd0);
            idle(int'($urandom_range(0, 2)));
        end
        noise = 1'b0;
        idle(30);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
